// File: rtl/ahb_lite_mem_tester_if.sv
// AHB-Lite bus bundle between the memory self-test master and the slave under test.
// Carries the single-master signal subset only; HSEL is driven by the master for a point-to-point link.
interface ahb_lite_mem_tester_if;
    logic [31:0] HADDR;
    logic [2:0]  HBURST;
    logic        HSEL;
    logic [2:0]  HSIZE;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    modport master (
        output HADDR, HBURST, HSEL, HSIZE, HTRANS, HWRITE, HWDATA,
        input  HRDATA, HREADY, HRESP
    );

    modport slave (
        input  HADDR, HBURST, HSEL, HSIZE, HTRANS, HWRITE, HWDATA,
        output HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/ahb_lite_mem_tester.sv
// Pipelined AHB-Lite self-test master: writes a pattern over a word range, waits,
// reads it back and counts mismatches / error responses for bring-up debug.
module ahb_lite_mem_tester #(
    parameter logic [31:0] ADDR_BASE  = 32'h0,
    parameter logic [31:0] ADDR_LAST  = 32'h80,
    parameter int unsigned DELAY_BITS = 12,
    parameter logic [31:0] LFSR_SEED  = 32'h1
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  START,
    input  logic [1:0]            MODE,
    input  logic                  LOOP,
    ahb_lite_mem_tester_if.master bus,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [31:0]           ERRCOUNT,
    output logic [31:0]           FIRST_ERR,
    output logic [15:0]           PASSCOUNT
);

    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_WDRAIN, S_DELAY, S_READ, S_RDRAIN, S_DONE
    } state_t;

    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    state_t                  state, next_state;
    logic [31:0]             haddr;
    logic                    nonseq;
    logic                    hwrite;
    logic [31:0]             dp_addr;
    logic [31:0]             dp_data;
    logic                    dp_valid;
    logic [DELAY_BITS-1:0]   delay_cnt;
    logic [31:0]             lfsr;
    logic [31:0]             lfsr_save;
    logic [1:0]              mode_q;
    logic [31:0]             errcount;
    logic [31:0]             first_err;
    logic [15:0]             passcount;

    logic                    start_run;
    logic                    accept;
    logic                    wdrain_done;
    logic                    rdrain_done;
    logic                    delay_done;
    logic                    at_last;
    logic [31:0]             exp_data;
    logic [31:0]             lfsr_next;
    logic                    in_read_dp;
    logic                    in_write_dp;
    logic                    err_beat;

    assign at_last   = (haddr == ADDR_LAST);
    assign lfsr_next = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_TAPS : 32'h0);

    always_comb begin
        case (mode_q)
            2'd1:    exp_data = ~haddr;
            2'd2:    exp_data = lfsr;
            default: exp_data = haddr;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state <= S_IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state  = state;
        start_run   = 1'b0;
        accept      = 1'b0;
        wdrain_done = 1'b0;
        rdrain_done = 1'b0;
        delay_done  = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (START) begin
                    start_run  = 1'b1;
                    next_state = S_WRITE;
                end
            end
            S_WRITE: begin
                if (bus.HREADY) begin
                    accept = 1'b1;
                    if (at_last) next_state = S_WDRAIN;
                end
            end
            S_WDRAIN: begin
                if (bus.HREADY) begin
                    wdrain_done = 1'b1;
                    next_state  = S_DELAY;
                end
            end
            S_DELAY: begin
                if (&delay_cnt) begin
                    delay_done = 1'b1;
                    next_state = S_READ;
                end
            end
            S_READ: begin
                if (bus.HREADY) begin
                    accept = 1'b1;
                    if (at_last) next_state = S_RDRAIN;
                end
            end
            S_RDRAIN: begin
                if (bus.HREADY) begin
                    rdrain_done = 1'b1;
                    next_state  = LOOP ? S_WRITE : S_DONE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Address phase, data phase and pattern generator; the read pass replays the
    // LFSR from its value at write entry so both passes see the same sequence.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            haddr     <= ADDR_BASE;
            nonseq    <= 1'b0;
            hwrite    <= 1'b0;
            dp_addr   <= 32'h0;
            dp_data   <= 32'h0;
            dp_valid  <= 1'b0;
            delay_cnt <= '0;
            lfsr      <= LFSR_SEED;
            lfsr_save <= LFSR_SEED;
            mode_q    <= 2'd0;
        end else begin
            if (start_run) begin
                haddr     <= ADDR_BASE;
                nonseq    <= 1'b1;
                hwrite    <= 1'b1;
                mode_q    <= MODE;
                lfsr_save <= lfsr;
            end
            if (accept) begin
                dp_addr  <= haddr;
                dp_data  <= exp_data;
                dp_valid <= 1'b1;
                if (mode_q == 2'd2) lfsr <= lfsr_next;
                if (at_last) begin
                    nonseq <= 1'b0;
                    hwrite <= 1'b0;
                end else begin
                    haddr <= haddr + 32'd4;
                end
            end
            if (wdrain_done) begin
                dp_valid  <= 1'b0;
                delay_cnt <= '0;
            end
            if (state == S_DELAY) begin
                delay_cnt <= delay_cnt + DELAY_BITS'(1);
                if (delay_done) begin
                    haddr  <= ADDR_BASE;
                    nonseq <= 1'b1;
                    hwrite <= 1'b0;
                    lfsr   <= lfsr_save;
                end
            end
            if (rdrain_done) begin
                dp_valid <= 1'b0;
                if (LOOP) begin
                    haddr     <= ADDR_BASE;
                    nonseq    <= 1'b1;
                    hwrite    <= 1'b1;
                    lfsr_save <= lfsr;
                end
            end
        end
    end

    // A data mismatch and an ERROR response on the same beat count as one error.
    assign in_read_dp  = (state == S_READ)  || (state == S_RDRAIN);
    assign in_write_dp = (state == S_WRITE) || (state == S_WDRAIN);
    assign err_beat    = dp_valid && bus.HREADY &&
                         ((in_read_dp && ((bus.HRDATA != dp_data) || bus.HRESP)) ||
                          (in_write_dp && bus.HRESP));

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            errcount  <= 32'h0;
            first_err <= 32'h0;
            passcount <= 16'h0;
        end else if (start_run) begin
            errcount  <= 32'h0;
            first_err <= 32'h0;
            passcount <= 16'h0;
        end else begin
            if (err_beat && (errcount != 32'hFFFF_FFFF)) errcount <= errcount + 32'd1;
            if (err_beat && (errcount == 32'h0))         first_err <= dp_addr;
            if (rdrain_done)                             passcount <= passcount + 16'd1;
        end
    end

    assign bus.HADDR  = haddr;
    assign bus.HBURST = 3'b000;
    assign bus.HSEL   = 1'b1;
    assign bus.HSIZE  = 3'b010;
    assign bus.HTRANS = nonseq ? 2'b10 : 2'b00;
    assign bus.HWRITE = hwrite;
    assign bus.HWDATA = dp_data;

    assign BUSY      = (state != S_IDLE) && (state != S_DONE);
    assign DONE      = (state == S_DONE);
    assign ERRCOUNT  = errcount;
    assign FIRST_ERR = first_err;
    assign PASSCOUNT = passcount;

endmodule

// File: tb/tb_ahb_lite_mem_tester.sv
// Bench for ahb_lite_mem_tester: scoreboard of expected bus transfers from a pass-level
// model, a stalling/corrupting memory slave, plus a single-word-range instance.
module tb_ahb_lite_mem_tester;

    localparam logic [31:0] BASE   = 32'h0;
    localparam logic [31:0] LAST   = 32'h10;
    localparam int          NWORDS = 5;
    localparam logic [31:0] SEED   = 32'h1;
    localparam logic [31:0] B1     = 32'h40;
    localparam int          TMO    = 4000;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        start, loop, start1;
    logic [1:0]  mode;
    logic        busy, done, busy1, done1;
    logic [31:0] errcount, first_err, errcount1, first_err1;
    logic [15:0] passcount, passcount1;

    ahb_lite_mem_tester_if bus0 ();
    ahb_lite_mem_tester_if bus1 ();

    always #5 HCLK = ~HCLK;

    ahb_lite_mem_tester #(.ADDR_BASE(BASE), .ADDR_LAST(LAST), .DELAY_BITS(3), .LFSR_SEED(SEED)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .START(start), .MODE(mode), .LOOP(loop), .bus(bus0),
        .BUSY(busy), .DONE(done), .ERRCOUNT(errcount), .FIRST_ERR(first_err), .PASSCOUNT(passcount)
    );

    ahb_lite_mem_tester #(.ADDR_BASE(B1), .ADDR_LAST(B1), .DELAY_BITS(2), .LFSR_SEED(SEED)) dut1 (
        .HCLK(HCLK), .HRESETn(HRESETn), .START(start1), .MODE(2'd2), .LOOP(1'b0), .bus(bus1),
        .BUSY(busy1), .DONE(done1), .ERRCOUNT(errcount1), .FIRST_ERR(first_err1), .PASSCOUNT(passcount1)
    );

    int checks   = 0;
    int failures = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic timeoutFail(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s: wait bound expired", name);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
    } xfer_t;

    xfer_t       exp_q[$];
    logic [31:0] lfsr_m;

    // Galois form of x^32 + x^22 + x^2 + x + 1
    function automatic logic [31:0] lfsrStep(input logic [31:0] v);
        return (v >> 1) ^ (v[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    function automatic logic [31:0] modelData(input logic [31:0] a, input int md);
        case (md)
            1:       return ~a;
            2:       return lfsr_m;
            default: return a;
        endcase
    endfunction

    task automatic pushPass(input int md);
        logic [31:0] save, end_w, a;
        save = lfsr_m;
        for (int i = 0; i < NWORDS; i++) begin
            a = BASE + 32'(4 * i);
            exp_q.push_back('{1'b1, a, modelData(a, md)});
            if (md == 2) lfsr_m = lfsrStep(lfsr_m);
        end
        end_w  = lfsr_m;
        lfsr_m = save;
        for (int i = 0; i < NWORDS; i++) begin
            a = BASE + 32'(4 * i);
            exp_q.push_back('{1'b0, a, modelData(a, md)});
            if (md == 2) lfsr_m = lfsrStep(lfsr_m);
        end
        lfsr_m = end_w;
    endtask

    // ---------------- slave 0: memory with stalls and fault injection ----------------
    logic [31:0] mem0 [0:63];
    logic        s_valid, s_write;
    logic [31:0] s_addr;
    logic        stall_en = 1'b0;
    logic        corrupt_en = 1'b0, resp_en = 1'b0;
    logic [31:0] corrupt_addr = 32'h0, resp_addr = 32'h0;
    int          stall_left = 0;

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            s_valid <= 1'b0;
            s_write <= 1'b0;
            s_addr  <= 32'h0;
        end else if (bus0.HREADY) begin
            if (s_valid && s_write) mem0[s_addr[7:2]] <= bus0.HWDATA;
            s_valid <= (bus0.HTRANS == 2'b10);
            s_write <= bus0.HWRITE;
            s_addr  <= bus0.HADDR;
        end
    end

    assign bus0.HRDATA = (s_valid && !s_write) ?
                         (mem0[s_addr[7:2]] ^ {31'b0, corrupt_en && (s_addr == corrupt_addr)}) : 32'h0;
    assign bus0.HRESP  = s_valid && !s_write && resp_en && (s_addr == resp_addr);

    initial bus0.HREADY = 1'b1;
    always @(posedge HCLK) begin
        #1;
        if (stall_left > 0) begin
            bus0.HREADY = 1'b0;
            stall_left--;
        end else begin
            bus0.HREADY = 1'b1;
            if (stall_en) stall_left = $urandom_range(0, 3);
        end
    end

    // ---------------- slave 1: single-word zero-wait memory ----------------
    logic        s1_valid, s1_write;
    logic [31:0] mem1;
    int          wr1_cnt = 0, rd1_cnt = 0;

    assign bus1.HREADY = 1'b1;
    assign bus1.HRESP  = 1'b0;
    assign bus1.HRDATA = mem1;

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            s1_valid <= 1'b0;
            s1_write <= 1'b0;
            mem1     <= 32'h0;
        end else begin
            if (s1_valid && s1_write) mem1 <= bus1.HWDATA;
            s1_valid <= (bus1.HTRANS == 2'b10);
            s1_write <= bus1.HWRITE;
        end
    end

    always @(negedge HCLK) begin
        if (HRESETn && bus1.HTRANS == 2'b10) begin
            checkOutput("single-word HADDR", bus1.HADDR, B1);
            if (bus1.HWRITE) wr1_cnt++;
            else             rd1_cnt++;
        end
    end

    // ---------------- monitor / scoreboard for dut ----------------
    logic        mon_dp_valid = 1'b0, mon_dp_wr = 1'b0;
    logic [31:0] mon_dp_data;
    logic        prev_stall = 1'b0, prev_dstall = 1'b0;
    logic [31:0] prev_addr, prev_wdata;
    logic        prev_write;
    xfer_t       e;

    always @(negedge HCLK) begin
        if (!HRESETn) begin
            mon_dp_valid = 1'b0;
            prev_stall   = 1'b0;
            prev_dstall  = 1'b0;
        end else begin
            if (prev_stall) begin
                checkOutput("stall HADDR", bus0.HADDR, prev_addr);
                checkOutput("stall HTRANS", 32'(bus0.HTRANS), 32'h2);
                checkOutput("stall HWRITE", 32'(bus0.HWRITE), 32'(prev_write));
            end
            if (prev_dstall) checkOutput("stall HWDATA", bus0.HWDATA, prev_wdata);
            if (bus0.HREADY && mon_dp_valid && mon_dp_wr)
                checkOutput("HWDATA", bus0.HWDATA, mon_dp_data);
            if (bus0.HREADY) mon_dp_valid = 1'b0;
            if (bus0.HREADY && bus0.HTRANS == 2'b10) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected transfer: got HADDR 0x%08h HWRITE %0d, none required",
                             bus0.HADDR, bus0.HWRITE);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("HADDR", bus0.HADDR, e.addr);
                    checkOutput("HWRITE", 32'(bus0.HWRITE), 32'(e.wr));
                    mon_dp_valid = 1'b1;
                    mon_dp_wr    = e.wr;
                    mon_dp_data  = e.data;
                end
            end
            prev_stall  = !bus0.HREADY && (bus0.HTRANS == 2'b10);
            prev_addr   = bus0.HADDR;
            prev_write  = bus0.HWRITE;
            prev_dstall = !bus0.HREADY && mon_dp_valid && mon_dp_wr;
            prev_wdata  = bus0.HWDATA;
        end
    end

    // ---------------- stimulus ----------------
    task automatic checkReset();
        checkOutput("reset HADDR", bus0.HADDR, BASE);
        checkOutput("reset HTRANS", 32'(bus0.HTRANS), 32'h0);
        checkOutput("reset HWRITE", 32'(bus0.HWRITE), 32'h0);
        checkOutput("reset HWDATA", bus0.HWDATA, 32'h0);
        checkOutput("reset BUSY", 32'(busy), 32'h0);
        checkOutput("reset DONE", 32'(done), 32'h0);
        checkOutput("reset ERRCOUNT", errcount, 32'h0);
        checkOutput("reset FIRST_ERR", first_err, 32'h0);
        checkOutput("reset PASSCOUNT", 32'(passcount), 32'h0);
    endtask

    task automatic applyStimulus(input int md, input int passes, input bit stalls,
                                 input bit c_en, input logic [31:0] c_addr,
                                 input bit r_en, input logic [31:0] r_addr);
        int n;
        stall_en     = stalls;
        corrupt_en   = c_en;
        corrupt_addr = c_addr;
        resp_en      = r_en;
        resp_addr    = r_addr;
        for (int p = 0; p < passes; p++) pushPass((md == 3) ? 0 : md);
        @(posedge HCLK); #1;
        start = 1'b1;
        mode  = 2'(md);
        loop  = (passes > 1);
        @(posedge HCLK); #1;
        start = 1'b0;
        if (passes > 1) begin
            n = 0;
            while (passcount != 16'(passes - 1) && n < TMO) begin
                @(negedge HCLK);
                n++;
            end
            if (n >= TMO) timeoutFail("loop pass wait");
            loop = 1'b0;
        end
    endtask

    task automatic waitDone();
        int n;
        n = 0;
        while (!done && n < TMO) begin
            @(negedge HCLK);
            n++;
        end
        if (n >= TMO) timeoutFail("DONE wait");
    endtask

    task automatic checkRun(input string tag, input logic [31:0] e_err,
                            input logic [31:0] e_first, input logic [15:0] e_pass);
        @(negedge HCLK);
        $display("[TB] end of run %s", tag);
        checkOutput({tag, " DONE"}, 32'(done), 32'h1);
        checkOutput({tag, " BUSY"}, 32'(busy), 32'h0);
        checkOutput({tag, " ERRCOUNT"}, errcount, e_err);
        checkOutput({tag, " FIRST_ERR"}, first_err, e_first);
        checkOutput({tag, " PASSCOUNT"}, 32'(passcount), 32'(e_pass));
        checkOutput({tag, " transfers left"}, 32'(exp_q.size()), 32'h0);
    endtask

    initial begin
        int          n, md, passes;
        bit          c_en, st;
        logic [31:0] c_addr;

        HRESETn = 1'b0;
        start   = 1'b0;
        start1  = 1'b0;
        loop    = 1'b0;
        mode    = 2'd0;
        lfsr_m  = SEED;
        repeat (3) @(posedge HCLK);
        #1;
        checkReset();
        HRESETn = 1'b1;

        applyStimulus(0, 1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        waitDone();
        checkRun("mode0 zero-wait", 32'd0, 32'h0, 16'd1);

        @(posedge HCLK); #1;
        wr1_cnt = 0;
        rd1_cnt = 0;
        start1  = 1'b1;
        @(posedge HCLK); #1;
        start1 = 1'b0;
        n = 0;
        while (!done1 && n < TMO) begin
            @(negedge HCLK);
            n++;
        end
        if (n >= TMO) timeoutFail("single-word DONE wait");
        checkOutput("single-word writes", 32'(wr1_cnt), 32'd1);
        checkOutput("single-word reads", 32'(rd1_cnt), 32'd1);
        checkOutput("single-word data", mem1, SEED);
        checkOutput("single-word ERRCOUNT", errcount1, 32'h0);
        checkOutput("single-word PASSCOUNT", 32'(passcount1), 32'd1);

        applyStimulus(0, 2, 1'b0, 1'b1, 32'h8, 1'b0, 32'h0);
        waitDone();
        checkRun("corrupt 0x8 two passes", 32'd2, 32'h8, 16'd2);

        applyStimulus(2, 1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        waitDone();
        checkRun("mode2 stalls", 32'd0, 32'h0, 16'd1);

        applyStimulus(2, 3, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        waitDone();
        checkRun("mode2 loop x3", 32'd0, 32'h0, 16'd3);

        applyStimulus(3, 1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hC);
        waitDone();
        checkRun("hresp on good read", 32'd1, 32'hC, 16'd1);

        applyStimulus(1, 1, 1'b1, 1'b1, 32'h8, 1'b1, 32'h8);
        waitDone();
        checkRun("hresp plus corrupt same beat", 32'd1, 32'h8, 16'd1);

        applyStimulus(1, 1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h4);
        waitDone();
        checkRun("two error beats", 32'd2, 32'h4, 16'd1);

        for (int k = 0; k < 4; k++) begin
            md     = $urandom_range(0, 3);
            passes = $urandom_range(1, 2);
            st     = 1'($urandom_range(0, 1));
            c_en   = 1'($urandom_range(0, 1));
            c_addr = BASE + 32'(4 * $urandom_range(0, NWORDS - 1));
            applyStimulus(md, passes, st, c_en, c_addr, 1'b0, 32'h0);
            waitDone();
            checkRun($sformatf("random %0d", k), c_en ? 32'(passes) : 32'd0,
                     c_en ? c_addr : 32'h0, 16'(passes));
        end

        applyStimulus(2, 1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        n = 0;
        while (!(bus0.HTRANS == 2'b10 && !bus0.HWRITE) && n < TMO) begin
            @(negedge HCLK);
            n++;
        end
        if (n >= TMO) timeoutFail("read phase wait");
        #2;
        HRESETn = 1'b0;
        #1;
        checkReset();
        exp_q.delete();
        lfsr_m = SEED;
        repeat (2) @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        applyStimulus(2, 1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        waitDone();
        checkRun("after mid-read reset", 32'd0, 32'h0, 16'd1);

        repeat (2) @(posedge HCLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
